mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 WIDTH, 8, operand width in bits, matching the shared multiplier.
REQ-002 N_REQ, 4, number of requesters, 2..8; IDW = $clog2(N_REQ).
REQ-003 TIMEOUT_CYCLES, 64, WAIT-state watchdog limit; used only with MULT_ARB_TIMEOUT_EN.
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  N_REQ  per-requester request; requester holds it and its operands until req_ready.
REQ-007 req_a, req_b  in  N_REQ*WIDTH each  signed operands; slice i belongs to requester i.
REQ-008 req_ready  out  N_REQ  one-hot accept; request i is taken when req_valid[i] and req_ready[i] are both 1.
REQ-009 resp_valid  out  1  response available; held until resp_ready.
REQ-010 resp_ready  in  1  consumer accepts the response.
REQ-011 resp_id  out  IDW  index of the requester being answered.
REQ-012 resp_product  out  2*WIDTH  signed product.
REQ-013 resp_err  out  1  response aborted by timeout.
REQ-014 mul_start  out  1  single-cycle start pulse to the shared multiplier.
REQ-015 mul_multiplicand, mul_multiplier  out  WIDTH each  operands, stable from ISSUE until completion.
REQ-016 mul_product  in  2*WIDTH  multiplier result, valid while mul_done=1.
REQ-017 mul_done  in  1  multiplier done level; it stays high until the next start is accepted.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE->ISSUE on an accept.
- ISSUE->WAIT unconditionally.
- WAIT->RESPOND on completion (or timeout).
- RESPOND->IDLE on resp_ready.
REQ-020 In IDLE, req_ready is combinational.
- It is one-hot to the round-robin winner among asserted req_valid bits.
- The search starts at last_grant+1 modulo N_REQ.
- req_ready is all-zero in all other states.
REQ-021 On accept:
- Operands and winner id are registered into mul_multiplicand, mul_multiplier and resp_id.
- last_grant is updated to the winner.
REQ-022 In ISSUE, mul_start = 1 for exactly one cycle; mul_start is 0 in all other states.
REQ-023 Completion is a 0->1 transition of mul_done sampled in WAIT (mul_done registered as mul_done_q).
- A level of mul_done left high by the previous operation is never treated as completion.
REQ-024 On completion, mul_product is registered into resp_product, resp_err = 0, and resp_valid rises on the next cycle.
REQ-025 In RESPOND:
- resp_valid, resp_id, resp_product and resp_err hold until the cycle with resp_ready = 1.
- resp_valid drops the following cycle.
REQ-026 Latency: an accept at cycle T gives mul_start at T+1; resp_valid rises one cycle after the completion edge is sampled.
REQ-027 One operation is in flight at a time; no grants occur while resp_valid is stalled by resp_ready = 0.
REQ-028 No req_valid: the block stays in IDLE with all outputs at their hold values.
REQ-029 req_valid withdrawn before grant: the request is not serviced and last_grant is unchanged.
REQ-030 All N_REQ requesting continuously: grants rotate 0,1,..,N_REQ-1,0 with no starvation.
REQ-031 If resp_ready is already 1 when RESPOND is entered, RESPOND lasts one cycle; the next grant can occur in the following IDLE cycle.

Reset
REQ-032 rst_n low, at any time including mid-operation, forces:
- state to IDLE;
- req_ready, mul_start, resp_valid, resp_err and busy to 0;
- resp_product, resp_id and mul operands to 0;
- mul_done_q and the timeout counter to 0;
- last_grant to N_REQ-1, so the first grant goes to requester 0.
REQ-033 An in-flight operation is discarded without a response; the multiplier is reset by the shared rst_n.

Configuration
REQ-034 MULT_ARB_TIMEOUT_EN defined:
- A counter runs in WAIT.
- If TIMEOUT_CYCLES cycles pass without completion, the FSM enters RESPOND with resp_err = 1 and resp_product = 0.
REQ-035 MULT_ARB_TIMEOUT_EN undefined: no counter is present, resp_err is tied 0, and WAIT waits indefinitely.

Structure
REQ-036 Package mult_arb_pkg holds the state enum type and the default parameter constants.
REQ-037 Sub-module mult_rr_picker holds the combinational round-robin winner selection (req_valid, last_grant -> one-hot grant, index).

Verification
REQ-038 Single request, id 2, a = 0xFD (-3), b = 0x07 -> one mul_start; resp_id = 2, resp_product = 0xFFEB (-21), resp_err = 0.
REQ-039 All four requesting from reset, resp_ready = 1 -> grant order 0,1,2,3,0; each product correct (e.g. 0x80*0x80 = 0x4000).
REQ-040 Back-to-back operations with mul_done still high from the previous op -> no early completion; the second product is correct.
REQ-041 resp_ready held 0 for 20 cycles -> resp_valid and data stable, req_ready all 0, no mul_start.
REQ-042 rst_n pulsed low during WAIT -> all outputs go to reset values immediately; the next request is granted to requester 0.
REQ-043 With MULT_ARB_TIMEOUT_EN and mul_done tied 0 -> resp_valid with resp_err = 1 and product 0 exactly TIMEOUT_CYCLES cycles after entering WAIT.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and default sizing for the shared-multiplier arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } arb_state_e;

    localparam int DEF_WIDTH          = 8;
    localparam int DEF_N_REQ          = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/mult_arb_picker.sv
// Combinational round-robin winner selection: search starts one past last_grant.
module mult_rr_picker #(
    parameter int N_REQ = 4,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [IDW-1:0]   last_grant_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDW-1:0]   grant_idx_o
);

    always_comb begin
        logic found;
        int   cand;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_grant_i) + k) % N_REQ;
            if (!found && req_valid_i[cand]) begin
                found             = 1'b1;
                grant_o[cand]     = 1'b1;
                grant_idx_o       = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of one shared signed multiplier, one op in flight.
// Optional WAIT watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int N_REQ          = DEF_N_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDW           = $clog2(N_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0]               req_valid_i,
    input  logic [N_REQ-1:0][WIDTH-1:0]    req_a_i,
    input  logic [N_REQ-1:0][WIDTH-1:0]    req_b_i,
    output logic [N_REQ-1:0]               req_ready_o,
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic [IDW-1:0]                 resp_id_o,
    output logic [2*WIDTH-1:0]             resp_product_o,
    output logic                           resp_err_o,
    output logic                           mul_start_o,
    output logic [WIDTH-1:0]               mul_multiplicand_o,
    output logic [WIDTH-1:0]               mul_multiplier_o,
    input  logic [2*WIDTH-1:0]             mul_product_i,
    input  logic                           mul_done_i,
    output logic                           busy_o
);

    arb_state_e          state_q;
    logic [IDW-1:0]      last_grant_q;
    logic [IDW-1:0]      resp_id_q;
    logic [WIDTH-1:0]    mcand_q, mplier_q;
    logic [2*WIDTH-1:0]  resp_product_q;
    logic                mul_done_q;
    logic [N_REQ-1:0]    grant;
    logic [IDW-1:0]      grant_idx;
    logic                done_rise;

    mult_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_valid_i  (req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    // A done level left over from the previous op must not count; only a fresh rise does.
    assign done_rise = mul_done_i && !mul_done_q;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] to_cnt_q;
    logic           resp_err_q;
    assign resp_err_o = resp_err_q;
`else
    assign resp_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            last_grant_q   <= IDW'(N_REQ - 1);
            resp_id_q      <= '0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            resp_product_q <= '0;
            mul_done_q     <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            to_cnt_q       <= '0;
            resp_err_q     <= 1'b0;
`endif
        end else begin
            mul_done_q <= mul_done_i;
            case (state_q)
                S_IDLE: begin
                    if (|grant) begin
                        mcand_q      <= req_a_i[grant_idx];
                        mplier_q     <= req_b_i[grant_idx];
                        resp_id_q    <= grant_idx;
                        last_grant_q <= grant_idx;
                        state_q      <= S_ISSUE;
`ifdef MULT_ARB_TIMEOUT_EN
                        to_cnt_q     <= '0;
                        resp_err_q   <= 1'b0;
`endif
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (done_rise) begin
                        resp_product_q <= mul_product_i;
                        state_q        <= S_RESPOND;
                    end
`ifdef MULT_ARB_TIMEOUT_EN
                    else if (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
                        resp_product_q <= '0;
                        resp_err_q     <= 1'b1;
                        state_q        <= S_RESPOND;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                S_RESPOND: begin
                    if (resp_ready_i) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o        = (state_q == S_IDLE) ? grant : '0;
    assign mul_start_o        = (state_q == S_ISSUE);
    assign resp_valid_o       = (state_q == S_RESPOND);
    assign busy_o             = (state_q != S_IDLE);
    assign resp_id_o          = resp_id_q;
    assign resp_product_o     = resp_product_q;
    assign mul_multiplicand_o = mcand_q;
    assign mul_multiplier_o   = mplier_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural shared-multiplier stub.
module tb_mult_arbiter;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;
    localparam int IDW   = 2;
    localparam int TO    = 64;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0][WIDTH-1:0] req_a, req_b;
    logic [N_REQ-1:0]            req_ready;
    logic                        resp_valid, resp_ready, resp_err;
    logic [IDW-1:0]              resp_id;
    logic [2*WIDTH-1:0]          resp_product;
    logic                        mul_start, mul_done, busy;
    logic [WIDTH-1:0]            mul_multiplicand, mul_multiplier;
    logic [2*WIDTH-1:0]          mul_product;

    int checks = 0;
    int errors = 0;

    mult_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .TIMEOUT_CYCLES(TO)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid_i        (req_valid),
        .req_a_i            (req_a),
        .req_b_i            (req_b),
        .req_ready_o        (req_ready),
        .resp_valid_o       (resp_valid),
        .resp_ready_i       (resp_ready),
        .resp_id_o          (resp_id),
        .resp_product_o     (resp_product),
        .resp_err_o         (resp_err),
        .mul_start_o        (mul_start),
        .mul_multiplicand_o (mul_multiplicand),
        .mul_multiplier_o   (mul_multiplier),
        .mul_product_i      (mul_product),
        .mul_done_i         (mul_done),
        .busy_o             (busy)
    );

    // Multiplier stub: done drops one cycle after start, rises LAT cycles after start.
    logic [1:0]  mcnt;
    logic        mdrop, mdone, tie0;
    logic [15:0] mprod;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt <= '0; mdrop <= 1'b0; mdone <= 1'b0; mprod <= '0;
        end else if (mul_start) begin
            mcnt  <= 2'(LAT);
            mdrop <= 1'b1;
        end else begin
            if (mdrop) begin
                mdone <= 1'b0;
                mdrop <= 1'b0;
            end
            if (mcnt != 0) begin
                mcnt <= mcnt - 1'b1;
                if (mcnt == 2'd1) begin
                    mdone <= 1'b1;
                    mprod <= $signed({{8{mul_multiplicand[7]}}, mul_multiplicand}) *
                             $signed({{8{mul_multiplier[7]}}, mul_multiplier});
                end
            end
        end
    end
    assign mul_done    = tie0 ? 1'b0 : mdone;
    assign mul_product = mprod;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(input int max, output int n);
        n = 0;
        while (resp_valid !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, starts;
        logic [15:0] hold_p;
        logic [IDW-1:0] hold_id;
        logic [3:0] exp_ids [5];
        logic [15:0] exp_p [4];
        logic stable;

        req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0; tie0 = 1'b0;
        #12;
        // Reset state
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_mul_start", 32'(mul_start), 0);
        chk("rst_operands", {16'(mul_multiplicand), 16'(mul_multiplier)}, 0);
        tick();
        rst_n = 1'b1;

        // No requests: stays idle
        tick(); tick(); tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_mul_start", 32'(mul_start), 0);

        // Single request from id 2: -3 * 7
        req_a[2] = 8'hFD; req_b[2] = 8'h07; req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        chk("single_start", 32'(mul_start), 1);
        chk("single_operands", {16'(mul_multiplicand), 16'(mul_multiplier)}, {16'h00FD, 16'h0007});
        starts = 1;
        n = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
            if (mul_start) starts++;
        end
        chk("single_latency", n, 5);
        chk("single_starts", starts, 1);
        chk("single_id", 32'(resp_id), 2);
        chk("single_product", 32'(resp_product), 32'hFFEB);
        chk("single_err", 32'(resp_err), 0);
        resp_ready = 1'b1;
        tick();
        chk("single_drop", 32'(resp_valid), 0);

        // Round robin from reset, all requesting, resp_ready high
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req_a[0] = 8'h80; req_b[0] = 8'h80;
        req_a[1] = 8'h05; req_b[1] = 8'h06;
        req_a[2] = 8'h7F; req_b[2] = 8'hFF;
        req_a[3] = 8'hF0; req_b[3] = 8'h10;
        exp_p[0] = 16'h4000; exp_p[1] = 16'h001E; exp_p[2] = 16'hFF81; exp_p[3] = 16'hFF00;
        exp_ids[0] = 4'b0001; exp_ids[1] = 4'b0010; exp_ids[2] = 4'b0100;
        exp_ids[3] = 4'b1000; exp_ids[4] = 4'b0001;
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            chk("rr_grant", 32'(req_ready), 32'(exp_ids[g]));
            tick();
            wait_resp(50, n);
            // Back-to-back ops see a stale done level at WAIT entry; latency must not shrink
            chk("rr_latency", n, 5);
            chk("rr_product", 32'(resp_product), 32'(exp_p[g % 4]));
            tick();
        end

        // Stall: resp_ready low for 20 cycles (last grant 0, next is 1)
        resp_ready = 1'b0;
        chk("stall_grant", 32'(req_ready), 32'b0010);
        tick();
        wait_resp(50, n);
        hold_p = resp_product; hold_id = resp_id;
        chk("stall_product", 32'(hold_p), 32'h001E);
        for (int c = 0; c < 20; c++) begin
            tick();
            stable = resp_valid && resp_product == hold_p && resp_id == hold_id &&
                     req_ready == '0 && !mul_start;
            chk("stall_hold", 32'(stable), 1);
        end
        resp_ready = 1'b1;
        tick();
        chk("stall_release", 32'(resp_valid), 0);
        chk("stall_next_grant", 32'(req_ready), 32'b0100);
        req_valid = '0;
        tick();

        // Reset during WAIT
        req_valid = 4'b1000;
        #1;
        tick();
        req_valid = '0;
        tick(); tick();
        chk("mid_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_regs", {16'(resp_id), 8'(mul_multiplicand), 8'(mul_multiplier)}, 0);
        chk("mid_rst_product", 32'(resp_product), 0);
        tick();
        rst_n = 1'b1;

        // Withdrawn request leaves last_grant at 3, so {3,0} picks 0
        req_valid = 4'b0100;
        #1;
        req_valid = '0;
        tick();
        chk("withdraw_idle", 32'(busy), 0);
        req_valid = 4'b1001;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        wait_resp(50, n);
        chk("post_rst_id", 32'(resp_id), 0);
        chk("post_rst_product", 32'(resp_product), 32'h4000);
        tick();

`ifdef MULT_ARB_TIMEOUT_EN
        // Watchdog: done never rises
        tie0 = 1'b1;
        req_valid = 4'b0010;
        #1;
        tick();
        req_valid = '0;
        tick();
        chk("to_in_wait", 32'(busy && !mul_start && !resp_valid), 1);
        wait_resp(200, n);
        chk("to_latency", n, TO);
        chk("to_err", 32'(resp_err), 1);
        chk("to_product", 32'(resp_product), 0);
        tick();
        tie0 = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
